// File: rtl/pht_pkg.sv
// Shared types and helpers for the pattern-history-table read/update path.
// Holds the 2-bit counter encodings and the saturating next-state rule.
package pht_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int CTR_W   = 2;

    typedef enum logic [CTR_W-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    // Saturating step toward the resolved outcome: never wraps past SNT or ST.
    function automatic logic [CTR_W-1:0] sat_next(input logic [CTR_W-1:0] cur,
                                                  input logic             taken);
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating branch counter; steps toward 'taken' when inc_en is high.
module sat_counter2
    import pht_pkg::*;
#(
    parameter logic [CTR_W-1:0] INIT_STATE = WNT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc_en,
    input  logic             taken,
    output logic [CTR_W-1:0] state
);

    // NOTE: each counter is a real flop with its own reset, so the whole table
    // comes up in a known weakly-not-taken state rather than as uninitialised RAM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= INIT_STATE;
        end else if (inc_en) begin
            state <= sat_next(state, taken);
        end
    end

endmodule

// File: rtl/pht_predict_reader.sv
// Pattern history table with a registered prediction read port and a mispredict counter.
// Define PHT_BYPASS_EN to forward a same-cycle, same-index update onto the read result.
module pht_predict_reader
    import pht_pkg::*;
#(
    parameter int               ENTRIES    = pht_pkg::ENTRIES,
    parameter logic [CTR_W-1:0] INIT_STATE = WNT,
    parameter int               MISS_W     = 16,
    localparam int              IDX_W      = $clog2(ENTRIES)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [IDX_W-1:0]  column,
    input  logic              OUTCOME,
    input  logic              READ_EN,
    input  logic [IDX_W-1:0]  read_column,
    output logic              PREDICTION,
    output logic              PRED_VALID,
    output logic [CTR_W-1:0]  PRED_STATE,
    output logic [MISS_W-1:0] MISS_COUNT
);

    logic [ENTRIES-1:0] upd_en;
    logic [CTR_W-1:0]   ctr [ENTRIES];
    logic [CTR_W-1:0]   rd_val;
    logic               mispredict;

    // NOTE: default every always_comb output before any conditional write,
    // otherwise the untouched bits hold their value and become latches.
    always_comb begin
        upd_en = '0;
        if (ENABLE) upd_en[column] = 1'b1;
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        sat_counter2 #(.INIT_STATE(INIT_STATE)) u_ctr (
            .CLK    (CLK),
            .RESET  (RESET),
            .inc_en (upd_en[i]),
            .taken  (OUTCOME),
            .state  (ctr[i])
        );
    end

    assign mispredict = ENABLE && (ctr[column][CTR_W-1] != OUTCOME);

    always_comb begin
        rd_val = ctr[read_column];
`ifdef PHT_BYPASS_EN
        if (ENABLE && (column == read_column)) rd_val = sat_next(ctr[column], OUTCOME);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes read-before-write hold.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PREDICTION <= 1'b0;
            PRED_VALID <= 1'b0;
            PRED_STATE <= '0;
            MISS_COUNT <= '0;
        end else begin
            PRED_VALID <= READ_EN;
            if (READ_EN) begin
                PRED_STATE <= rd_val;
                PREDICTION <= rd_val[CTR_W-1];
            end
            if (mispredict && (MISS_COUNT != '1)) MISS_COUNT <= MISS_COUNT + MISS_W'(1);
        end
    end

endmodule

// File: tb/tb_pht_predict_reader.sv
// Self-checking bench for pht_predict_reader: directed plan plus random traffic
// against an integer-level model of the counter table.
module tb_pht_predict_reader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [3:0]  column;
    logic        OUTCOME;
    logic        READ_EN;
    logic [3:0]  read_column;
    logic        PREDICTION;
    logic        PRED_VALID;
    logic [1:0]  PRED_STATE;
    logic [15:0] MISS_COUNT;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers, saturation via min/max arithmetic.
    int m_ctr [16];
    int m_miss;
    int m_valid;
    int m_state;

    pht_predict_reader dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .column      (column),
        .OUTCOME     (OUTCOME),
        .READ_EN     (READ_EN),
        .read_column (read_column),
        .PREDICTION  (PREDICTION),
        .PRED_VALID  (PRED_VALID),
        .PRED_STATE  (PRED_STATE),
        .MISS_COUNT  (MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies the current inputs for one clock edge, advances the model and compares.
    task automatic step();
        int rd;
        int nxt;
        if (RESET) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_miss  = 0;
            m_valid = 0;
            m_state = 0;
        end else begin
            nxt = OUTCOME ? ((m_ctr[column] + 1 > 3) ? 3 : m_ctr[column] + 1)
                          : ((m_ctr[column] - 1 < 0) ? 0 : m_ctr[column] - 1);
            rd = m_ctr[read_column];
`ifdef PHT_BYPASS_EN
            if (ENABLE && column == read_column) rd = nxt;
`endif
            m_valid = READ_EN ? 1 : 0;
            if (READ_EN) m_state = rd;
            if (ENABLE) begin
                if ((m_ctr[column] >= 2) != OUTCOME && m_miss < 65535) m_miss++;
                m_ctr[column] = nxt;
            end
        end
        @(posedge CLK);
        #1;
        check("pred_valid", PRED_VALID, m_valid);
        check("pred_state", PRED_STATE, m_state);
        check("prediction", PREDICTION, (m_state >= 2) ? 1 : 0);
        check("miss_count", MISS_COUNT, m_miss);
    endtask

    task automatic drive(input logic rst, input logic en, input logic [3:0] col,
                         input logic out, input logic ren, input logic [3:0] rcol);
        RESET = rst; ENABLE = en; column = col; OUTCOME = out;
        READ_EN = ren; read_column = rcol;
        step();
    endtask

    initial begin
        // 1: reset, then read index 2
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_valid", PRED_VALID, 0);
        check("rst_miss", MISS_COUNT, 0);
        drive(0, 0, 0, 0, 1, 4'h2);
        check("t1_valid", PRED_VALID, 1);
        check("t1_state", PRED_STATE, 2'b01);
        check("t1_pred", PREDICTION, 0);

        // 2: three taken updates to index 8, read, then a fourth taken update
        repeat (3) drive(0, 1, 4'h8, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h8);
        check("t2_state", PRED_STATE, 2'b11);
        check("t2_pred", PREDICTION, 1);
        drive(0, 1, 4'h8, 1, 1, 4'h8);
        drive(0, 0, 0, 0, 1, 4'h8);
        check("t2_sat_state", PRED_STATE, 2'b11);
        check("t2_miss", MISS_COUNT, 1);

        // 3: four not-taken updates to index 4 saturate at 00
        repeat (4) drive(0, 1, 4'h4, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h4);
        check("t3_state", PRED_STATE, 2'b00);
        check("t3_pred", PREDICTION, 0);
        check("t3_miss", MISS_COUNT, 1);

        // 4: same-cycle update and read of index 2
        drive(0, 1, 4'h2, 1, 1, 4'h2);
`ifdef PHT_BYPASS_EN
        check("t4_same_cycle", PRED_STATE, 2'b10);
`else
        check("t4_same_cycle", PRED_STATE, 2'b01);
`endif
        drive(0, 0, 0, 0, 1, 4'h2);
        check("t4_follow", PRED_STATE, 2'b10);

        // 5: ENABLE low with a live column/OUTCOME changes nothing
        repeat (5) drive(0, 0, 4'h3, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 4'h3);
        check("t5_state", PRED_STATE, 2'b01);
        check("t5_miss", MISS_COUNT, 2);

        // 6: reset overrides concurrent read and update
        repeat (3) drive(0, 1, 4'h8, 1, 0, 0);
        drive(1, 1, 4'h8, 0, 1, 4'h8);
        check("t6_no_valid", PRED_VALID, 0);
        drive(0, 0, 0, 0, 1, 4'h8);
        check("t6_state", PRED_STATE, 2'b01);
        check("t6_miss", MISS_COUNT, 0);

        // Random traffic, including same-index collisions and occasional reset
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pht_predict_reader.md
Name: pht_predict_reader

Overview:
- Read-side partner of the 1-to-16 outcome demux (`demuxTwo`) in the 4-bit branch-prediction path.
- Holds 16 two-bit saturating counters.
  - Updated through the same column/OUTCOME/ENABLE write interface that the demux drives.
  - Read through an independent index port that returns a registered taken/not-taken prediction.
- Sits in the IF stage.
  - Fetch supplies the read index.
  - EX/branch resolution supplies updates.
- Also keeps a saturating mispredict counter for performance debug.

Parameters:
- ENTRIES, 16, number of counters; power of two; IDX_W = log2(ENTRIES) = 4.
- CTR_W, 2, counter width; the MSB is the prediction.
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken).
- MISS_W, 16, width of the mispredict counter.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  update valid; same meaning as on the demux.
- column  input  IDX_W  update index.
- OUTCOME  input  1  resolved branch outcome; 1 = taken.
- READ_EN  input  1  prediction request valid.
- read_column  input  IDX_W  prediction index.
- PREDICTION  output  1  registered prediction (counter MSB).
- PRED_VALID  output  1  one-cycle pulse qualifying PREDICTION.
- PRED_STATE  output  CTR_W  full counter value behind PREDICTION.
- MISS_COUNT  output  MISS_W  saturating count of mispredicted updates.

Behaviour:
- Reset (RESET high at a CLK edge): every counter goes to INIT_STATE, and PREDICTION, PRED_VALID, PRED_STATE and MISS_COUNT go to 0.
  - RESET overrides any concurrent ENABLE or READ_EN.
  - A read issued in the cycle RESET is asserted produces no PRED_VALID.
- Update when ENABLE=1 at an edge: ctr[column] <= OUTCOME ? sat_inc : sat_dec.
  - Saturation: 11 + taken stays 11; 00 + not-taken stays 00.
  - ENABLE=0: no counter changes; column and OUTCOME are ignored.
- Mispredict: when ENABLE=1 and the pre-update ctr[column][CTR_W-1] differs from OUTCOME, MISS_COUNT increments.
  - Saturates at all-ones and never wraps.
- Read when READ_EN=1 at edge N, valid at edge N+1 (latency 1):
  - PRED_STATE <= ctr[read_column].
  - PREDICTION <= ctr[read_column][CTR_W-1].
  - PRED_VALID <= 1.
- READ_EN=0: PRED_VALID <= 0; PREDICTION and PRED_STATE hold their last values.
- Back-to-back reads: one result per cycle, no stalls.
- Update and read to different indices in the same cycle: fully independent.
- Update and read to the same index in the same cycle: read-before-write.
  - The returned value is the pre-update counter unless PHT_BYPASS_EN is defined.
- No internal state machine beyond the counter array and registers. Counter state encoding:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T

Optional Feature:
- Macro: PHT_BYPASS_EN.
- Defined: on a same-cycle, same-index read and update, PREDICTION and PRED_STATE return the post-update (saturated) value. This costs one extra comparator and mux on the read path.
- Undefined: read-before-write as stated in Behaviour.

Decomposition:
- Shared package `pht_pkg` holds:
  - Counter encodings SNT/WNT/WT/ST.
  - ENTRIES, IDX_W, CTR_W defaults.
  - A function returning the saturating next state from (current, outcome).
- Sub-module `sat_counter2` is the natural split.
  - One 2-bit saturating counter with CLK, RESET, inc_en, taken, state.
  - Instantiated ENTRIES times by a generate loop; enables are decoded from column and ENABLE, mirroring the demux.

Test Plan:
1. Reset, then READ_EN=1 with read_column=4'h2 → next cycle PRED_VALID=1, PRED_STATE=01, PREDICTION=0, MISS_COUNT=0.
2. Three updates with ENABLE=1, column=4'h8, OUTCOME=1, then read index 8:
   - PRED_STATE=11, PREDICTION=1.
   - A fourth taken update leaves the counter at 11.
   - MISS_COUNT=1: only the first update, made at 01, mispredicted.
3. Four updates with column=4'h4, OUTCOME=0 → counter saturates at 00; read index 4 gives PREDICTION=0; MISS_COUNT unchanged.
4. Same-cycle update (column=4'h2, OUTCOME=1, counter at 01) and read of index 2:
   - Without PHT_BYPASS_EN: PRED_STATE=01.
   - With PHT_BYPASS_EN: PRED_STATE=10.
   - The following read returns 10 in both builds.
5. ENABLE=0 with column=4'h3 and OUTCOME=1 for 5 cycles → index 3 still reads 01; MISS_COUNT unchanged.
6. Drive index 8 to 11, assert RESET for 1 cycle while READ_EN=1 and ENABLE=1 → no PRED_VALID the next cycle; index 8 reads 01; MISS_COUNT=0.
